// File: rtl/alu_pkg.sv
// Shared ALU select codes and multiply sequencer state encoding.
// Imported by the ALU datapath and by alu_mult_seq.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// Unsigned WLxWL->2WL shift-add multiplier that borrows the shared ALU.
// Optional MULT_ZERO_SKIP_EN: zero operand goes straight to DONE.
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int WL = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WL-1:0] a,
    input  logic [WL-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [WL-1:0] hi,
    output logic [WL-1:0] lo,
    output logic          alu_own,
    output logic [WL-1:0] alu_x,
    output logic [WL-1:0] alu_y,
    output logic [2:0]    alu_sel,
    input  logic [WL-1:0] alu_out
);

    localparam int CW = $clog2(WL) + 1;

    seq_state_t    r_state;
    logic [WL-1:0] r_mcand;
    logic [WL-1:0] r_hi;
    logic [WL-1:0] r_lo;
    logic [CW-1:0] r_cnt;
    logic          w_iter;
    logic          w_carry;

    assign w_iter = (r_state == S_ITER);

    // Carry-out of hi+mcand recovered from the MSBs and the ALU sum bit.
    assign w_carry = (r_hi[WL-1] & r_mcand[WL-1]) |
                     ((r_hi[WL-1] | r_mcand[WL-1]) & ~alu_out[WL-1]);

    // Sequencer FSM: capture, WL shift-add steps, one-cycle done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
`ifdef MULT_ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            r_hi    <= '0;
                            r_lo    <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= b;
                            r_cnt   <= CW'(WL);
                            r_state <= S_ITER;
                        end
`else
                        r_hi    <= '0;
                        r_lo    <= b;
                        r_cnt   <= CW'(WL);
                        r_state <= S_ITER;
`endif
                    end
                end
                S_ITER: begin
                    if (r_lo[0]) begin
                        {r_hi, r_lo} <= {w_carry, alu_out, r_lo[WL-1:1]};
                    end else begin
                        {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WL-1:1]};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign alu_own = w_iter;
    assign alu_x   = w_iter ? r_hi : '0;
    assign alu_y   = w_iter ? r_mcand : '0;
    assign alu_sel = ALU_ADD;

endmodule
